// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end command generator: fetch-queue entry, PC-gen command,
// message type and FSM state encodings.
package bp_fe_pkg;

    localparam int VADDR_W = 39;
    localparam int INSTR_W = 32;
    localparam int META_W  = 36;

    localparam logic [VADDR_W-1:0] FIRST_PC = 39'h00_8000_0000;

    typedef enum logic [1:0] {
        FE_MSG_INSTR     = 2'd0,
        FE_MSG_EXCEPTION = 2'd1
    } bp_fe_msg_type_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } bp_fe_state_e;

    typedef struct packed {
        bp_fe_msg_type_e     msg_type;
        logic [VADDR_W-1:0]  pc;
        logic [INSTR_W-1:0]  instr;
        logic [META_W-1:0]   branch_metadata_fwd;
    } bp_fe_queue_s;

    typedef struct packed {
        logic [VADDR_W-1:0]  pc;
        logic [META_W-1:0]   branch_metadata_fwd;
        logic                pc_redirect_valid;
        logic                attaboy_valid;
    } bp_fe_pc_gen_cmd_s;

    // Builds a command from a resolution; redirect and attaboy are mutually exclusive.
    function automatic bp_fe_pc_gen_cmd_s make_cmd(input logic [VADDR_W-1:0] pc,
                                                   input logic [META_W-1:0]  meta,
                                                   input logic               redirect);
        bp_fe_pc_gen_cmd_s c;
        c.pc                  = pc;
        c.branch_metadata_fwd = meta;
        c.pc_redirect_valid   = redirect;
        c.attaboy_valid       = ~redirect;
        return c;
    endfunction

endpackage

// File: rtl/bp_fe_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module bp_fe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bp_fe_cmd_gen.sv
// Front-end command generator: forwards fetch entries, turns resolutions into PC-gen
// commands and drops wrong-path entries after a redirect. Define BP_FE_CMD_GEN_ATTABOY_EN
// to also emit attaboy commands on correct predictions.
module bp_fe_cmd_gen
    import bp_fe_pkg::*;
#(
    parameter int                     vaddr_width_p               = 39,
    parameter int                     instr_width_p               = 32,
    parameter int                     branch_metadata_fwd_width_p = 36,
    parameter logic [VADDR_W-1:0]     bp_first_pc_p               = FIRST_PC
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  bp_fe_queue_s                           fe_queue_i,
    input  logic                                   fe_queue_v_i,
    output logic                                   fe_queue_ready_o,

    output bp_fe_queue_s                           issue_o,
    output logic                                   issue_v_o,
    input  logic                                   issue_ready_i,

    input  logic                                   res_v_i,
    output logic                                   res_ready_o,
    input  logic                                   res_mispredict_i,
    input  logic [vaddr_width_p-1:0]               res_npc_i,
    input  logic [branch_metadata_fwd_width_p-1:0] res_metadata_i,

    output bp_fe_pc_gen_cmd_s                      fe_cmd_o,
    output logic                                   fe_cmd_v_o,
    input  logic                                   fe_cmd_ready_i,

    output logic [15:0]                            drop_cnt_o
);

    // The packed structs are sized by the package; reject mismatched overrides.
    if (vaddr_width_p != VADDR_W || instr_width_p != INSTR_W
        || branch_metadata_fwd_width_p != META_W) begin : g_width_check
        $error("bp_fe_cmd_gen: parameter widths must match bp_fe_pkg");
    end

`ifdef BP_FE_CMD_GEN_ATTABOY_EN
    localparam logic ATTABOY_EN = 1'b1;
`else
    localparam logic ATTABOY_EN = 1'b0;
`endif

    bp_fe_state_e       r_state;
    logic [VADDR_W-1:0] r_expected_pc;
    bp_fe_pc_gen_cmd_s  r_cmd;
    logic               r_cmd_v;

    logic w_match;
    logic w_res_acc;
    logic w_cmd_load;
    logic w_cmd_hs;
    logic w_issue_hs;
    logic w_drop;

    assign w_match    = (fe_queue_i.pc == r_expected_pc);
    assign w_res_acc  = res_v_i & res_ready_o;
    assign w_cmd_load = w_res_acc & (res_mispredict_i | ATTABOY_EN);
    assign w_cmd_hs   = r_cmd_v & fe_cmd_ready_i;
    assign w_issue_hs = issue_v_o & issue_ready_i;

    always_comb begin
        issue_o          = fe_queue_i;
        issue_v_o        = 1'b0;
        fe_queue_ready_o = 1'b1;
        res_ready_o      = 1'b0;
        w_drop           = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                issue_v_o        = fe_queue_v_i;
                fe_queue_ready_o = issue_ready_i;
                res_ready_o      = ~r_cmd_v | fe_cmd_ready_i;
            end
            ST_REDIRECT: begin
                w_drop = fe_queue_v_i;
            end
            ST_FLUSH: begin
                if (w_match) begin
                    issue_v_o        = fe_queue_v_i;
                    fe_queue_ready_o = issue_ready_i;
                end else begin
                    w_drop = fe_queue_v_i;
                end
            end
            default: begin
                w_drop = fe_queue_v_i;
            end
        endcase
    end

    // A new command may only load when the register is empty or draining this cycle,
    // so fe_cmd_o is stable for as long as fe_cmd_v_o waits on the front end.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state       <= ST_FLUSH;
            r_expected_pc <= bp_first_pc_p;
            r_cmd         <= '0;
            r_cmd_v       <= 1'b0;
        end else begin
            if (w_cmd_load) begin
                r_cmd   <= make_cmd(res_npc_i, res_metadata_i, res_mispredict_i);
                r_cmd_v <= 1'b1;
            end else if (w_cmd_hs) begin
                r_cmd_v <= 1'b0;
            end

            unique case (r_state)
                ST_RUN: begin
                    if (w_res_acc && res_mispredict_i) begin
                        r_expected_pc <= res_npc_i;
                        r_state       <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (w_cmd_hs) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_issue_hs) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_FLUSH;
                end
            endcase
        end
    end

    assign fe_cmd_o   = r_cmd;
    assign fe_cmd_v_o = r_cmd_v;

    bp_fe_sat_counter #(
        .WIDTH (16)
    ) u_drop_cnt (
        .i_clk   (clk_i),
        .i_rst_n (reset_i),
        .i_inc   (w_drop),
        .o_cnt   (drop_cnt_o)
    );

endmodule

// File: tb/tb_bp_fe_cmd_gen.sv
// Self-checking bench for bp_fe_cmd_gen: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the command generator.
module tb_bp_fe_cmd_gen;
    import bp_fe_pkg::*;

    logic               clk_i = 1'b0;
    logic               reset_i;
    bp_fe_queue_s       fe_queue_i;
    logic               fe_queue_v_i;
    logic               fe_queue_ready_o;
    bp_fe_queue_s       issue_o;
    logic               issue_v_o;
    logic               issue_ready_i;
    logic               res_v_i;
    logic               res_ready_o;
    logic               res_mispredict_i;
    logic [38:0]        res_npc_i;
    logic [35:0]        res_metadata_i;
    bp_fe_pc_gen_cmd_s  fe_cmd_o;
    logic               fe_cmd_v_o;
    logic               fe_cmd_ready_i;
    logic [15:0]        drop_cnt_o;

    always #5 clk_i = ~clk_i;

    bp_fe_cmd_gen dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .issue_o          (issue_o),
        .issue_v_o        (issue_v_o),
        .issue_ready_i    (issue_ready_i),
        .res_v_i          (res_v_i),
        .res_ready_o      (res_ready_o),
        .res_mispredict_i (res_mispredict_i),
        .res_npc_i        (res_npc_i),
        .res_metadata_i   (res_metadata_i),
        .fe_cmd_o         (fe_cmd_o),
        .fe_cmd_v_o       (fe_cmd_v_o),
        .fe_cmd_ready_i   (fe_cmd_ready_i),
        .drop_cnt_o       (drop_cnt_o)
    );

`ifdef BP_FE_CMD_GEN_ATTABOY_EN
    localparam bit ATTA = 1'b1;
`else
    localparam bit ATTA = 1'b0;
`endif

    localparam logic [38:0] PC0 = 39'h00_8000_0000;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = running, 1 = waiting for the redirect to be taken,
    // 2 = discarding entries until the expected PC shows up.
    int          m_mode;
    logic [38:0] m_exp_pc;
    bit          m_cmd_v;
    logic [38:0] m_cmd_pc;
    logic [35:0] m_cmd_meta;
    bit          m_cmd_redir;
    int          m_drops;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode      = 2;
        m_exp_pc    = PC0;
        m_cmd_v     = 1'b0;
        m_cmd_pc    = '0;
        m_cmd_meta  = '0;
        m_cmd_redir = 1'b0;
        m_drops     = 0;
    endtask

    task automatic idle_inputs();
        fe_queue_i       = '0;
        fe_queue_v_i     = 1'b0;
        issue_ready_i    = 1'b0;
        res_v_i          = 1'b0;
        res_mispredict_i = 1'b0;
        res_npc_i        = '0;
        res_metadata_i   = '0;
        fe_cmd_ready_i   = 1'b0;
    endtask

    // One clock: check registered outputs, drive inputs, check combinational
    // outputs, then advance the model across the rising edge.
    task automatic step(input bit qv, input logic [38:0] qpc, input bit ir,
                        input bit rv, input bit mis, input logic [38:0] npc, input bit cr);
        logic [63:0] r64;
        logic [35:0] meta;
        bit match, e_iv, e_qr, e_rr, racc, load, drop;
        @(negedge clk_i);
        check("cmd_v", 64'(fe_cmd_v_o), 64'(m_cmd_v));
        if (m_cmd_v) begin
            check("cmd_pc", 64'(fe_cmd_o.pc), 64'(m_cmd_pc));
            check("cmd_meta", 64'(fe_cmd_o.branch_metadata_fwd), 64'(m_cmd_meta));
            check("cmd_redirect", 64'(fe_cmd_o.pc_redirect_valid), 64'(m_cmd_redir));
            check("cmd_attaboy", 64'(fe_cmd_o.attaboy_valid), 64'(!m_cmd_redir));
        end
        check("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));

        r64 = {$urandom, $urandom};
        meta = r64[35:0];
        fe_queue_i.msg_type            = ($urandom_range(0, 3) == 0) ? FE_MSG_EXCEPTION : FE_MSG_INSTR;
        fe_queue_i.pc                  = qpc;
        fe_queue_i.instr               = $urandom;
        fe_queue_i.branch_metadata_fwd = meta;
        fe_queue_v_i     = qv;
        issue_ready_i    = ir;
        res_v_i          = rv;
        res_mispredict_i = mis;
        res_npc_i        = npc;
        r64 = {$urandom, $urandom};
        res_metadata_i   = r64[35:0];
        fe_cmd_ready_i   = cr;
        #1;

        match = (qpc == m_exp_pc);
        case (m_mode)
            0:       begin e_iv = qv;         e_qr = ir;               e_rr = !m_cmd_v || cr; end
            1:       begin e_iv = 1'b0;       e_qr = 1'b1;             e_rr = 1'b0;           end
            default: begin e_iv = qv && match; e_qr = match ? ir : 1'b1; e_rr = 1'b0;          end
        endcase
        check("issue_v", 64'(issue_v_o), 64'(e_iv));
        check("fe_queue_ready", 64'(fe_queue_ready_o), 64'(e_qr));
        check("res_ready", 64'(res_ready_o), 64'(e_rr));
        if (e_iv) begin
            check("issue_pc", 64'(issue_o.pc), 64'(qpc));
            check("issue_meta", 64'(issue_o.branch_metadata_fwd), 64'(meta));
        end

        racc = rv && e_rr;
        load = racc && (mis || ATTA);
        drop = qv && (m_mode == 1 || (m_mode == 2 && !match));

        @(posedge clk_i);
        if (drop && m_drops < 16'hFFFF) m_drops++;
        case (m_mode)
            0: if (racc && mis) begin m_mode = 1; m_exp_pc = npc; end
            1: if (m_cmd_v && cr) m_mode = 2;
            default: if (qv && match && ir) m_mode = 0;
        endcase
        if (load) begin
            m_cmd_v     = 1'b1;
            m_cmd_pc    = npc;
            m_cmd_meta  = res_metadata_i;
            m_cmd_redir = mis;
        end else if (cr) begin
            m_cmd_v = 1'b0;
        end
    endtask

    initial begin
        logic [38:0] qpc;
        logic [38:0] npc;
        idle_inputs();
        reset_i = 1'b0;
        model_reset();
        #12;
        check("reset_cmd_v", 64'(fe_cmd_v_o), 64'd0);
        check("reset_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("reset_state", 64'(dut.r_state), 64'(ST_FLUSH));
        @(negedge clk_i);
        reset_i = 1'b1;

        // Post-reset flush: wrong PC dropped, first PC issued.
        step(1, 39'h00_8000_0004, 1, 0, 0, '0, 0);
        step(1, 39'h00_8000_0000, 1, 0, 0, '0, 0);
        #1;
        check("boot_drop_cnt", 64'(drop_cnt_o), 64'd1);
        check("boot_state", 64'(dut.r_state), 64'(ST_RUN));

        // Mispredict, front end stalls three cycles.
        step(0, '0, 0, 1, 1, 39'h00_8000_0100, 0);
        #1;
        check("redir_v", 64'(fe_cmd_v_o), 64'd1);
        check("redir_pc", 64'(fe_cmd_o.pc), 64'h8000_0100);
        check("redir_flag", 64'(fe_cmd_o.pc_redirect_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 1, 0, 39'h00_8000_0200, 0);
            check("redir_stall_res_ready", 64'(res_ready_o), 64'd0);
        end
        step(0, '0, 0, 0, 0, '0, 1);
        step(1, 39'h00_8000_0010, 1, 0, 0, '0, 0);
        step(1, 39'h00_8000_0014, 1, 0, 0, '0, 0);
        step(1, 39'h00_8000_0100, 0, 0, 0, '0, 0);
        step(1, 39'h00_8000_0100, 1, 0, 0, '0, 0);
        #1;
        check("flush_drop_cnt", 64'(drop_cnt_o), 64'd3);
        check("flush_state", 64'(dut.r_state), 64'(ST_RUN));

        // Correct prediction.
        step(0, '0, 0, 1, 0, 39'h00_8000_0104, 0);
        #1;
        check("attaboy_v", 64'(fe_cmd_v_o), 64'(ATTA));
        if (ATTA) check("attaboy_flag", 64'(fe_cmd_o.attaboy_valid), 64'd1);
        step(0, '0, 0, 0, 0, '0, 1);

        // Asynchronous reset while a redirect is pending.
        step(0, '0, 0, 1, 1, 39'h00_8000_0300, 0);
        #2;
        check("pre_reset_state", 64'(dut.r_state), 64'(ST_REDIRECT));
        reset_i = 1'b0;
        #1;
        check("async_reset_cmd_v", 64'(fe_cmd_v_o), 64'd0);
        check("async_reset_state", 64'(dut.r_state), 64'(ST_FLUSH));
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b1;

        // Drop counter saturation.
        force dut.u_drop_cnt.r_cnt = 16'hFFFE;
        #1;
        release dut.u_drop_cnt.r_cnt;
        m_drops = 16'hFFFE;
        step(1, 39'h00_8000_0040, 1, 0, 0, '0, 0);
        step(1, 39'h00_8000_0044, 1, 0, 0, '0, 0);
        step(1, 39'h00_8000_0048, 1, 0, 0, '0, 0);
        #1;
        check("sat_drop_cnt", 64'(drop_cnt_o), 64'hFFFF);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    qpc = m_exp_pc;
                2:       qpc = m_exp_pc + 39'd4;
                default: qpc = PC0 + 39'($urandom_range(0, 15) * 4);
            endcase
            npc = PC0 + 39'($urandom_range(0, 15) * 4);
            step($urandom_range(0, 9) < 7, qpc, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, npc,
                 $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_fe_cmd_gen.md
BP_FE_CMD_GEN -- requirements
Module: bp_fe_cmd_gen

Interface
REQ-001 SHALL have parameter vaddr_width_p, 39, virtual PC width.
REQ-002 SHALL have parameter instr_width_p, 32, instruction width.
REQ-003 SHALL have parameter branch_metadata_fwd_width_p, 36, opaque predictor metadata width.
REQ-004 SHALL have parameter bp_first_pc_p, 0x8000_0000, first expected PC after reset.
REQ-005 SHALL have ports:
- clk_i  in  1  sole clock; reset is asynchronous and active-low.
- reset_i  in  1  asynchronous, active-low reset.
- fe_queue_i  in  bp_fe_queue_s  {msg_type, pc, instr, branch_metadata_fwd}.
- fe_queue_v_i  in  1  fetch entry valid.
- fe_queue_ready_o  out  1  entry accepted when v&ready.
- issue_o  out  bp_fe_queue_s  entry forwarded to backend.
- issue_v_o  out  1  forwarded entry valid.
- issue_ready_i  in  1  backend accepts entry.
- res_v_i  in  1  control-instruction resolution valid.
- res_ready_o  out  1  resolution accepted when v&ready.
- res_mispredict_i  in  1  resolved next PC differs from predicted path.
- res_npc_i  in  vaddr_width_p  architecturally correct next PC.
- res_metadata_i  in  branch_metadata_fwd_width_p  metadata of the resolved instruction.
- fe_cmd_o  out  bp_fe_pc_gen_cmd_s  {pc, branch_metadata_fwd, pc_redirect_valid, attaboy_valid}.
- fe_cmd_v_o  out  1  command valid.
- fe_cmd_ready_i  in  1  front end accepts command.
- drop_cnt_o  out  16  wrong-path entries dropped since reset, saturating.

Function
REQ-006 SHALL implement FSM states RUN, REDIRECT, FLUSH.
REQ-007 In RUN: issue_o = fe_queue_i, issue_v_o = fe_queue_v_i, fe_queue_ready_o = issue_ready_i, combinationally.
REQ-008 In RUN: res_ready_o = ~fe_cmd_v_o | fe_cmd_ready_i.
REQ-009 On an accepted resolution with res_mispredict_i=1, on the next clock:
- load command register {pc=res_npc_i, metadata=res_metadata_i, pc_redirect_valid=1, attaboy_valid=0};
- set fe_cmd_v_o=1;
- expected_pc <= res_npc_i;
- go to REDIRECT.
REQ-010 On an accepted resolution with res_mispredict_i=0, on the next clock: load an attaboy command {pc=res_npc_i, metadata, pc_redirect_valid=0, attaboy_valid=1} with fe_cmd_v_o=1, staying in RUN (see REQ-019).
REQ-011 fe_cmd_v_o SHALL hold with stable fe_cmd_o until fe_cmd_ready_i; it clears on the handshake clock unless a new command loads that same clock.
REQ-012 In REDIRECT and FLUSH:
- res_ready_o = 0;
- issue_v_o = 0;
- fe_queue_ready_o = 1, except when the entry matches (REQ-014).
REQ-013 REDIRECT SHALL go to FLUSH on the fe_cmd_ready_i handshake. Entries arriving in REDIRECT are dropped.
REQ-014 In FLUSH: an entry with pc == expected_pc is a match.
- A match is forwarded as in RUN (fe_queue_ready_o = issue_ready_i).
- FSM goes to RUN on the issue handshake.
- Non-matching entries are dropped.
REQ-015 Each dropped entry SHALL increment drop_cnt_o by 1, saturating at 0xFFFF.
REQ-016 PC comparison SHALL be full vaddr_width_p equality. Exception msg_type entries follow the same match/drop rules.
REQ-017 A match and an issue_ready_i=0 in the same FLUSH cycle SHALL hold the entry (not dropped, not counted).

Reset
REQ-018 Asserting reset_i (low) SHALL immediately set:
- state = FLUSH;
- expected_pc = bp_first_pc_p;
- fe_cmd_v_o = 0 and command register cleared;
- drop_cnt_o = 0.
This applies mid-operation too, discarding any pending command. Outputs derived combinationally follow REQ-012.

Configuration
REQ-019 With macro BP_FE_CMD_GEN_ATTABOY_EN defined, REQ-010 applies. Without it, correct-prediction resolutions are accepted with res_ready_o=1 in RUN and produce no command.

Structure
REQ-020 bp_fe_queue_s, bp_fe_pc_gen_cmd_s, the msg_type enum and the state enum SHALL live in bp_fe_pkg.
REQ-021 The drop counter SHALL be a separate sub-module, bp_fe_sat_counter (width parameter, increment, async active-low clear).

Verification
REQ-022 Reset, then entries at pc 0x8000_0004 and then 0x8000_0000 with issue_ready_i=1:
- first is dropped, drop_cnt_o=1;
- second is issued;
- state is RUN.
REQ-023 In RUN, mispredict resolution with res_npc_i=0x8000_0100:
- next cycle, fe_cmd_v_o=1 with pc=0x8000_0100 and pc_redirect_valid=1;
- with fe_cmd_ready_i=0 for 3 cycles, fe_cmd_o is stable and res_ready_o=0.
REQ-024 After the redirect handshake, entries at 0x8000_0010, 0x8000_0014 and then 0x8000_0100:
- drop_cnt_o increments by 2;
- 0x8000_0100 is issued;
- state is RUN.
REQ-025 With the macro defined, a correct resolution yields attaboy_valid=1 one cycle later. Without the macro, fe_cmd_v_o stays 0.
REQ-026 Force drop_cnt_o to 0xFFFF, then drop one entry: the counter stays 0xFFFF.
REQ-027 Assert reset_i low while in REDIRECT with fe_cmd_v_o=1: fe_cmd_v_o=0 and state=FLUSH immediately, without waiting for a clock edge.
